// File: rtl/game_state_ctrl.sv
// game_state_ctrl: session sequencer for the snake game. It steps through menu,
// start countdown, run, pause, respawn, game over and win. It also keeps lives
// and score, gates gameplay through play_en and supplies the HUD values.
module game_state_ctrl #(
   parameter int LIVES_W     = 2,
   parameter int MAX_LIVES   = 3,
   parameter int SCORE_W     = 8,
   parameter int WIN_SCORE   = 50,
   parameter int CNT_W       = 4,
   parameter int COUNT_TICKS = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               start_btn,
   input  logic               pause_btn,
   input  logic               bad_collision,
   input  logic               good_collision,
   output logic [2:0]         state,
   output logic [LIVES_W-1:0] lives,
   output logic [SCORE_W-1:0] score,
   output logic [CNT_W-1:0]   count,
   output logic               play_en,
   output logic               respawn
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_RUN       = 3'd2,
      ST_PAUSE     = 3'd3,
      ST_RESPAWN   = 3'd4,
      ST_GAME_OVER = 3'd5,
      ST_WIN       = 3'd6
   } state_t;

   localparam logic [SCORE_W-1:0] SCORE_MAX   = {SCORE_W{1'b1}};
   localparam logic [SCORE_W-1:0] SCORE_WIN   = SCORE_W'(WIN_SCORE);
   localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(MAX_LIVES);
   localparam logic [CNT_W-1:0]   COUNT_INIT  = CNT_W'(COUNT_TICKS);

   state_t             state_q,   state_d;
   logic [LIVES_W-1:0] lives_q,   lives_d;
   logic [SCORE_W-1:0] score_q,   score_d;
   logic [CNT_W-1:0]   count_q,   count_d;
   logic               respawn_q, respawn_d;

   // Button history. armed_q stays low for the first clock after reset. This
   // lets a button that is already held at reset release prime its history
   // without being seen as a fresh press.
   logic start_prev_q;
   logic pause_prev_q;
   logic armed_q;
   logic start_edge_s;
   logic pause_edge_s;
   logic [SCORE_W-1:0] score_inc_s;

   // Capture the previous button levels for rising-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_prev_q <= 1'b0;
         pause_prev_q <= 1'b0;
         armed_q      <= 1'b0;
      end else begin
         start_prev_q <= start_btn;
         pause_prev_q <= pause_btn;
         armed_q      <= 1'b1;
      end
   end

   assign start_edge_s = start_btn & ~start_prev_q & armed_q;
   assign pause_edge_s = pause_btn & ~pause_prev_q & armed_q;

   // Saturating score increment; the win check compares against this value.
   always_comb begin
      score_inc_s = score_q;
      if (score_q != SCORE_MAX) begin
         score_inc_s = score_q + SCORE_W'(1);
      end else begin
         score_inc_s = score_q;
      end
   end

   // Next-state, lives, score, countdown and respawn-pulse computation.
   always_comb begin
      state_d   = state_q;
      lives_d   = lives_q;
      score_d   = score_q;
      count_d   = count_q;
      respawn_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_edge_s) begin
               state_d = ST_COUNTDOWN;
               lives_d = LIVES_INIT;
               score_d = '0;
               count_d = COUNT_INIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_COUNTDOWN, ST_RESPAWN: begin
            if (tick) begin
               if (count_q <= CNT_W'(1)) begin
                  state_d = ST_RUN;
                  count_d = '0;
               end else begin
                  count_d = count_q - CNT_W'(1);
               end
            end else begin
               count_d = count_q;
            end
         end
         ST_RUN: begin
            if (bad_collision && (lives_q <= LIVES_W'(1))) begin
               lives_d = '0;
               state_d = ST_GAME_OVER;
            end else if (bad_collision) begin
               lives_d   = lives_q - LIVES_W'(1);
               count_d   = COUNT_INIT;
               state_d   = ST_RESPAWN;
               respawn_d = 1'b1;
            end else if (good_collision) begin
               score_d = score_inc_s;
               if (score_inc_s == SCORE_WIN) begin
                  state_d = ST_WIN;
               end else begin
                  state_d = ST_RUN;
               end
            end else if (pause_edge_s) begin
               state_d = ST_PAUSE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (pause_edge_s || start_edge_s) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         ST_GAME_OVER, ST_WIN: begin
            if (start_edge_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            // Code 7 is unreachable in normal operation; recover to the menu.
            state_d = ST_IDLE;
         end
      endcase
   end

   // Session registers; reset forces the menu state immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         lives_q   <= LIVES_INIT;
         score_q   <= '0;
         count_q   <= '0;
         respawn_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lives_q   <= lives_d;
         score_q   <= score_d;
         count_q   <= count_d;
         respawn_q <= respawn_d;
      end
   end

   assign state   = state_q;
   assign lives   = lives_q;
   assign score   = score_q;
   assign count   = count_q;
   assign respawn = respawn_q;
   assign play_en = (state_q == ST_RUN);

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: directed stimulus pushes expected
// outputs, and an independent monitor compares them after each clock edge and
// after an asynchronous reset.
module tb_game_state_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       start_btn = 1'b0;
   logic       pause_btn = 1'b0;
   logic       bad_collision = 1'b0;
   logic       good_collision = 1'b0;
   logic [2:0] state;
   logic [1:0] lives;
   logic [7:0] score;
   logic [3:0] count;
   logic       play_en;
   logic       respawn;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [2:0] st;
      logic [1:0] lv;
      logic [7:0] sc;
      logic [3:0] ct;
      logic       rs;
      logic       pe;
      string      tag;
   } exp_t;

   exp_t exp_q[$];

   game_state_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .tick           (tick),
      .start_btn      (start_btn),
      .pause_btn      (pause_btn),
      .bad_collision  (bad_collision),
      .good_collision (good_collision),
      .state          (state),
      .lives          (lives),
      .score          (score),
      .count          (count),
      .play_en        (play_en),
      .respawn        (respawn)
   );

   always #5 clk = ~clk;

   // Build an expected record; play_en is high only in RUN (code 2).
   function automatic exp_t mk(input logic [2:0] st, input logic [1:0] lv,
                               input logic [7:0] sc, input logic [3:0] ct,
                               input logic rs, input string tag);
      exp_t e;
      e.st  = st;
      e.lv  = lv;
      e.sc  = sc;
      e.ct  = ct;
      e.rs  = rs;
      e.pe  = (st == 3'd2);
      e.tag = tag;
      return e;
   endfunction

   // Apply one cycle of inputs {tick,start,pause,bad,good} from a negedge and
   // queue the outputs expected after the following rising edge.
   task automatic step(input logic [4:0] in, input exp_t e);
      tick           = in[4];
      start_btn      = in[3];
      pause_btn      = in[2];
      bad_collision  = in[1];
      good_collision = in[0];
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor: after each clock edge or reset assertion, pop and compare.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or posedge rst);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({state, lives, score, count, respawn, play_en} !==
                {e.st, e.lv, e.sc, e.ct, e.rs, e.pe}) begin
               n_err++;
               $display("FAIL %s: got st=%0d lv=%0d sc=%0d ct=%0d rs=%0b pe=%0b, want st=%0d lv=%0d sc=%0d ct=%0d rs=%0b pe=%0b",
                        e.tag, state, lives, score, count, respawn, play_en,
                        e.st, e.lv, e.sc, e.ct, e.rs, e.pe);
            end
         end
      end
   end

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state, start, countdown into RUN.
      step(5'b00000, mk(3'd0, 2'd3, 8'd0, 4'd0, 1'b0, "reset_idle"));
      step(5'b00000, mk(3'd0, 2'd3, 8'd0, 4'd0, 1'b0, "idle_hold"));
      step(5'b00100, mk(3'd0, 2'd3, 8'd0, 4'd0, 1'b0, "idle_pause_ign"));
      step(5'b01000, mk(3'd1, 2'd3, 8'd0, 4'd3, 1'b0, "start_edge"));
      step(5'b00000, mk(3'd1, 2'd3, 8'd0, 4'd3, 1'b0, "cd_hold"));
      step(5'b10000, mk(3'd1, 2'd3, 8'd0, 4'd2, 1'b0, "cd_tick1"));
      step(5'b10000, mk(3'd1, 2'd3, 8'd0, 4'd1, 1'b0, "cd_tick2"));
      step(5'b10000, mk(3'd2, 2'd3, 8'd0, 4'd0, 1'b0, "cd_tick3_run"));

      // Lose a life with lives=3, then respawn countdown.
      step(5'b00010, mk(3'd4, 2'd2, 8'd0, 4'd3, 1'b1, "bad_respawn"));
      step(5'b00000, mk(3'd4, 2'd2, 8'd0, 4'd3, 1'b0, "respawn_pulse_end"));
      step(5'b00100, mk(3'd4, 2'd2, 8'd0, 4'd3, 1'b0, "respawn_pause_ign"));
      step(5'b10000, mk(3'd4, 2'd2, 8'd0, 4'd2, 1'b0, "rsp_tick1"));
      step(5'b10000, mk(3'd4, 2'd2, 8'd0, 4'd1, 1'b0, "rsp_tick2"));
      step(5'b10000, mk(3'd2, 2'd2, 8'd0, 4'd0, 1'b0, "rsp_tick3_run"));
      step(5'b00001, mk(3'd2, 2'd2, 8'd1, 4'd0, 1'b0, "good_1"));

      // Held pause gives one edge; collisions and tick ignored while paused.
      step(5'b00100, mk(3'd3, 2'd2, 8'd1, 4'd0, 1'b0, "pause_edge"));
      for (int i = 0; i < 9; i++) begin
         step(5'b00100, mk(3'd3, 2'd2, 8'd1, 4'd0, 1'b0, "pause_held"));
      end
      step(5'b10111, mk(3'd3, 2'd2, 8'd1, 4'd0, 1'b0, "pause_collide_ign"));
      step(5'b00000, mk(3'd3, 2'd2, 8'd1, 4'd0, 1'b0, "pause_release"));
      step(5'b00100, mk(3'd2, 2'd2, 8'd1, 4'd0, 1'b0, "pause_resume"));
      step(5'b00000, mk(3'd2, 2'd2, 8'd1, 4'd0, 1'b0, "run_idle"));
      step(5'b01000, mk(3'd2, 2'd2, 8'd1, 4'd0, 1'b0, "run_start_ign"));
      step(5'b00000, mk(3'd2, 2'd2, 8'd1, 4'd0, 1'b0, "run_start_rel"));

      // Second life lost, down to one life.
      step(5'b00010, mk(3'd4, 2'd1, 8'd1, 4'd3, 1'b1, "bad_to_1"));
      step(5'b00010, mk(3'd4, 2'd1, 8'd1, 4'd3, 1'b0, "respawn_bad_ign"));
      step(5'b10000, mk(3'd4, 2'd1, 8'd1, 4'd2, 1'b0, "rsp2_tick1"));
      step(5'b10000, mk(3'd4, 2'd1, 8'd1, 4'd1, 1'b0, "rsp2_tick2"));
      step(5'b10000, mk(3'd2, 2'd1, 8'd1, 4'd0, 1'b0, "rsp2_run"));

      // Bad+good together at lives=1: game over, score unchanged.
      step(5'b00011, mk(3'd5, 2'd0, 8'd1, 4'd0, 1'b0, "bad_good_over"));
      step(5'b00001, mk(3'd5, 2'd0, 8'd1, 4'd0, 1'b0, "over_hold"));
      step(5'b01000, mk(3'd0, 2'd0, 8'd1, 4'd0, 1'b0, "over_to_idle"));
      step(5'b00000, mk(3'd0, 2'd0, 8'd1, 4'd0, 1'b0, "idle_persist"));

      // New game, run to a win at 50.
      step(5'b01000, mk(3'd1, 2'd3, 8'd0, 4'd3, 1'b0, "restart"));
      step(5'b10000, mk(3'd1, 2'd3, 8'd0, 4'd2, 1'b0, "cd2_tick1"));
      step(5'b10000, mk(3'd1, 2'd3, 8'd0, 4'd1, 1'b0, "cd2_tick2"));
      step(5'b10000, mk(3'd2, 2'd3, 8'd0, 4'd0, 1'b0, "cd2_run"));
      for (int i = 1; i <= 50; i++) begin
         step(5'b00001, mk((i == 50) ? 3'd6 : 3'd2, 2'd3, 8'(i), 4'd0, 1'b0, "score_run"));
      end
      step(5'b00001, mk(3'd6, 2'd3, 8'd50, 4'd0, 1'b0, "win_hold1"));
      step(5'b00001, mk(3'd6, 2'd3, 8'd50, 4'd0, 1'b0, "win_hold2"));
      step(5'b01000, mk(3'd0, 2'd3, 8'd50, 4'd0, 1'b0, "win_to_idle"));
      step(5'b00000, mk(3'd0, 2'd3, 8'd50, 4'd0, 1'b0, "idle_after_win"));

      // Asynchronous reset mid-countdown at count=2.
      step(5'b01000, mk(3'd1, 2'd3, 8'd0, 4'd3, 1'b0, "start3"));
      step(5'b00000, mk(3'd1, 2'd3, 8'd0, 4'd3, 1'b0, "start3_rel"));
      step(5'b10000, mk(3'd1, 2'd3, 8'd0, 4'd2, 1'b0, "cd3_tick1"));
      tick = 1'b0;
      #2;
      exp_q.push_back(mk(3'd0, 2'd3, 8'd0, 4'd0, 1'b0, "async_reset"));
      rst = 1'b1;
      start_btn = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // start_btn held through reset release must not start a game.
      for (int i = 0; i < 4; i++) begin
         step(5'b01000, mk(3'd0, 2'd3, 8'd0, 4'd0, 1'b0, "held_start_no_edge"));
      end
      step(5'b00000, mk(3'd0, 2'd3, 8'd0, 4'd0, 1'b0, "start_released"));
      step(5'b01000, mk(3'd1, 2'd3, 8'd0, 4'd3, 1'b0, "fresh_start"));

      // Make sure the monitor drained everything within a bounded wait.
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
         @(posedge clk);
      end
      #2;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected records left, want 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
